// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and sizes for the data-memory port arbiter.
package dmem_port_arbiter_pkg;

  localparam int DMEM_NUM_REQ = 2;
  localparam int DMEM_ADDR_W  = 32;
  localparam int DMEM_DATA_W  = 32;

  // P0_PRI: pipeline has fixed priority; P1_LOCK: debug/DMA holds a locked burst
  typedef enum logic {
    P0_PRI  = 1'b0,
    P1_LOCK = 1'b1
  } dmem_arb_state_t;

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Requester-side bundle: two request channels plus response and stall back to them.
interface dmem_port_arbiter_if;
  import dmem_port_arbiter_pkg::*;

  logic [DMEM_NUM_REQ-1:0]                  req_valid;
  logic [DMEM_NUM_REQ-1:0]                  req_ready;
  logic [DMEM_NUM_REQ-1:0]                  req_we;
  logic [DMEM_NUM_REQ-1:0]                  req_lock;
  logic [DMEM_NUM_REQ-1:0][DMEM_ADDR_W-1:0] req_addr;
  logic [DMEM_NUM_REQ-1:0][DMEM_DATA_W-1:0] req_wdata;
  logic [DMEM_NUM_REQ-1:0]                  resp_valid;
  logic [DMEM_DATA_W-1:0]                   resp_rdata;
  logic                                     pipe_stall;

  // Requesters (MEM stage and debug/DMA master)
  modport master (
    output req_valid, req_we, req_lock, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, pipe_stall
  );

  // Arbiter
  modport slave (
    input  req_valid, req_we, req_lock, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, pipe_stall
  );

endinterface

// File: rtl/dmem_port_arbiter.sv
// Arbitrates the single data-memory port between the pipeline (port 0) and the
// debug/DMA master (port 1). Port 0 has fixed priority except when port 1 has
// starved for STARVE_LIMIT cycles or is inside a locked burst of up to
// MAX_BURST beats. One read is outstanding at a time; its data is routed back
// to the owner one cycle after the transfer.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 8,
  parameter int MAX_BURST    = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  dmem_port_arbiter_if.slave     req_if,
  output logic                   mem_read_enable,
  output logic                   mem_write_enable,
  output logic [DMEM_ADDR_W-1:0] mem_addr,
  output logic [DMEM_DATA_W-1:0] mem_write_data,
  input  logic [DMEM_DATA_W-1:0] mem_read_data
);

  localparam int WC_W = $clog2(STARVE_LIMIT + 1);
  localparam int BC_W = $clog2(MAX_BURST + 1);
  localparam logic [WC_W-1:0] WAIT_MAX = WC_W'(STARVE_LIMIT);
  localparam logic [BC_W-1:0] BEAT_MAX = BC_W'(MAX_BURST);

  dmem_arb_state_t state;
  logic [WC_W-1:0] wait_cnt;
  logic [BC_W-1:0] beat_cnt;
  logic [BC_W-1:0] bc_nxt;
  logic [1:0]      grant;
  logic            sel_we;

  // Response tracker: one transfer in flight, owner and kind captured at transfer
  logic            vld_p1;
  logic            owner_p1;
  logic            we_p1;

  // Only the debug/DMA lock is honoured
  logic            unused_lock0;
  assign unused_lock0 = req_if.req_lock[0];

  // Starvation counter increment, holding at the force-grant threshold
  function automatic logic [WC_W-1:0] sat_inc(input logic [WC_W-1:0] v);
    return (v >= WAIT_MAX) ? v : v + WC_W'(1);
  endfunction

  assign bc_nxt = beat_cnt + BC_W'(1);

  // Grant decision: at most one port per cycle, nothing while reset is high
  always_comb begin
    grant = 2'b00;
    if (!reset) begin
      unique case (state)
        P0_PRI: begin
          if (req_if.req_valid[1] && ((wait_cnt >= WAIT_MAX) || !req_if.req_valid[0]))
            grant = 2'b10;
          else if (req_if.req_valid[0])
            grant = 2'b01;
        end
        P1_LOCK: begin
          if (req_if.req_valid[1])
            grant = 2'b10;
        end
        default: grant = 2'b00;
      endcase
    end
  end

  // Memory drive from the granted request; idle bus is all zero
  always_comb begin
    sel_we           = grant[1] ? req_if.req_we[1] : req_if.req_we[0];
    mem_read_enable  = (|grant) & ~sel_we;
    mem_write_enable = (|grant) & sel_we;
    mem_addr         = '0;
    mem_write_data   = '0;
    if (grant[1]) begin
      mem_addr       = req_if.req_addr[1];
      mem_write_data = req_if.req_wdata[1];
    end else if (grant[0]) begin
      mem_addr       = req_if.req_addr[0];
      mem_write_data = req_if.req_wdata[0];
    end
  end

  // Handshake and response outputs
  always_comb begin
    req_if.req_ready  = grant;
    req_if.pipe_stall = req_if.req_valid[0] & ~grant[0] & ~reset;
    req_if.resp_valid = 2'b00;
    req_if.resp_rdata = '0;
    if (vld_p1) begin
      req_if.resp_valid = owner_p1 ? 2'b10 : 2'b01;
      if (!we_p1)
        req_if.resp_rdata = mem_read_data;
    end
  end

  // Control state: FSM, starvation and burst counters, response valid
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= P0_PRI;
      wait_cnt <= '0;
      beat_cnt <= '0;
      vld_p1   <= 1'b0;
    end else begin
      vld_p1 <= |grant;

      if (!req_if.req_valid[1] || grant[1])
        wait_cnt <= '0;
      else
        wait_cnt <= sat_inc(wait_cnt);

      unique case (state)
        P0_PRI: begin
          // A burst that would already be full after this beat never enters lock
          if (grant[1] && req_if.req_lock[1] && (bc_nxt != BEAT_MAX)) begin
            state    <= P1_LOCK;
            beat_cnt <= bc_nxt;
          end
        end
        P1_LOCK: begin
          if (!req_if.req_valid[1] ||
              (grant[1] && (!req_if.req_lock[1] || (bc_nxt == BEAT_MAX)))) begin
            state    <= P0_PRI;
            beat_cnt <= '0;
            wait_cnt <= '0;
          end else if (grant[1]) begin
            beat_cnt <= bc_nxt;
          end
        end
        default: begin
          state    <= P0_PRI;
          beat_cnt <= '0;
        end
      endcase
    end
  end

  // Response owner/kind, captured on every transfer
  always_ff @(posedge clk) begin
    if (|grant) begin
      owner_p1 <= grant[1];
      we_p1    <= sel_we;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Directed bench for dmem_port_arbiter with a response scoreboard and a
// one-cycle-latency read-only memory model.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] rdata;
  } resp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_read_enable;
  logic        mem_write_enable;
  logic [31:0] mem_addr;
  logic [31:0] mem_write_data;
  logic [31:0] mem_read_data;

  int checks = 0;
  int errors = 0;
  resp_t sb[$];

  dmem_port_arbiter_if bus();

  dmem_port_arbiter #(.STARVE_LIMIT(8), .MAX_BURST(4)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_if           (bus),
    .mem_read_enable  (mem_read_enable),
    .mem_write_enable (mem_write_enable),
    .mem_addr         (mem_addr),
    .mem_write_data   (mem_write_data),
    .mem_read_data    (mem_read_data)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    if (a == 32'h10) return 32'hDEADBEEF;
    return {~a[15:0], a[15:0]} ^ 32'h1357_0000;
  endfunction

  always @(posedge clk) begin
    if (mem_read_enable) mem_read_data <= memfn(mem_addr);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check grant/bus before posedge, check response after it
  task automatic step(input logic [1:0] v, input logic [1:0] we, input logic [1:0] lk,
                      input logic [31:0] a0, input logic [31:0] a1,
                      input logic [31:0] d0, input logic [31:0] d1,
                      input logic [1:0] exp_rdy, input string tag);
    resp_t e;
    resp_t got;
    logic [31:0] ea;
    logic [31:0] ed;
    logic        ewe;
    @(negedge clk);
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_lock  = lk;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    #1;
    ewe = exp_rdy[1] ? we[1] : we[0];
    ea  = exp_rdy[1] ? a1 : (exp_rdy[0] ? a0 : 32'h0);
    ed  = exp_rdy[1] ? d1 : (exp_rdy[0] ? d0 : 32'h0);
    chk({tag, ".ready"}, {30'h0, bus.req_ready}, {30'h0, exp_rdy});
    chk({tag, ".stall"}, {31'h0, bus.pipe_stall}, {31'h0, v[0] & ~exp_rdy[0]});
    chk({tag, ".mem_en"}, {30'h0, mem_write_enable, mem_read_enable},
        {30'h0, (|exp_rdy) & ewe, (|exp_rdy) & ~ewe});
    chk({tag, ".mem_addr"}, mem_addr, ea);
    chk({tag, ".mem_wdata"}, mem_write_data, ed);
    e.vld   = exp_rdy;
    e.rdata = ((|exp_rdy) && !ewe) ? memfn(ea) : 32'h0;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk({tag, ".resp_valid"}, {30'h0, bus.resp_valid}, {30'h0, got.vld});
    chk({tag, ".resp_rdata"}, bus.resp_rdata, got.rdata);
  endtask

  initial begin
    bus.req_valid = 2'b11;
    bus.req_we    = 2'b00;
    bus.req_lock  = 2'b00;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.ready", {30'h0, bus.req_ready}, 32'h0);
    chk("rst.resp_valid", {30'h0, bus.resp_valid}, 32'h0);
    chk("rst.mem_en", {30'h0, mem_write_enable, mem_read_enable}, 32'h0);
    chk("rst.stall", {31'h0, bus.pipe_stall}, 32'h0);
    @(negedge clk);
    bus.req_valid = 2'b00;
    reset = 1'b0;

    // 1: lone pipeline load
    step(2'b01, 2'b00, 2'b00, 32'h10, 32'h0, 32'h0, 32'h0, 2'b01, "t1");

    // 2: both valid, starvation guard fires on the 9th cycle
    for (int i = 0; i < 10; i++)
      step(2'b11, 2'b00, 2'b00, 32'h100 + 32'(i * 4), 32'h2000, 32'h0, 32'h0,
           (i == 8) ? 2'b10 : 2'b01, $sformatf("t2[%0d]", i));

    // 3: locked burst of 6 stores capped at 4 beats, one pipeline beat in between
    step(2'b10, 2'b10, 2'b10, 32'h300, 32'h400, 32'h0, 32'hA000_0001, 2'b10, "t3[0]");
    step(2'b11, 2'b10, 2'b10, 32'h300, 32'h404, 32'h0, 32'hA000_0002, 2'b10, "t3[1]");
    step(2'b11, 2'b10, 2'b10, 32'h300, 32'h408, 32'h0, 32'hA000_0003, 2'b10, "t3[2]");
    step(2'b11, 2'b10, 2'b10, 32'h300, 32'h40C, 32'h0, 32'hA000_0004, 2'b10, "t3[3]");
    step(2'b11, 2'b10, 2'b10, 32'h300, 32'h410, 32'h0, 32'hA000_0005, 2'b01, "t3[4]");
    step(2'b10, 2'b10, 2'b10, 32'h300, 32'h410, 32'h0, 32'hA000_0005, 2'b10, "t3[5]");
    step(2'b10, 2'b10, 2'b10, 32'h300, 32'h414, 32'h0, 32'hA000_0006, 2'b10, "t3[6]");
    step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, "t3[7]");
    step(2'b11, 2'b00, 2'b10, 32'h304, 32'h418, 32'h0, 32'h0, 2'b01, "t3[8]");

    // 4: alternating pipeline store / debug load
    for (int i = 0; i < 6; i++) begin
      if (i % 2 == 0)
        step(2'b01, 2'b01, 2'b00, 32'h500 + 32'(i * 4), 32'h0, 32'h5500_0000 + 32'(i), 32'h0,
             2'b01, $sformatf("t4[%0d]", i));
      else
        step(2'b10, 2'b00, 2'b00, 32'h0, 32'h600 + 32'(i * 4), 32'h0, 32'h0,
             2'b10, $sformatf("t4[%0d]", i));
    end

    // 5: reset right after a locked debug load transfer
    @(negedge clk);
    bus.req_valid = 2'b10;
    bus.req_we    = 2'b00;
    bus.req_lock  = 2'b10;
    bus.req_addr  = {32'h44, 32'h48};
    #1;
    chk("t5.ready", {30'h0, bus.req_ready}, 32'h2);
    @(posedge clk);
    #1;
    reset = 1'b1;
    bus.req_valid = 2'b11;
    #1;
    chk("t5.resp_valid", {30'h0, bus.resp_valid}, 32'h0);
    chk("t5.resp_rdata", bus.resp_rdata, 32'h0);
    chk("t5.ready", {30'h0, bus.req_ready}, 32'h0);
    chk("t5.mem_en", {30'h0, mem_write_enable, mem_read_enable}, 32'h0);
    chk("t5.mem_addr", mem_addr, 32'h0);
    chk("t5.mem_wdata", mem_write_data, 32'h0);
    chk("t5.stall", {31'h0, bus.pipe_stall}, 32'h0);
    chk("t5.state", {31'h0, dut.state}, {31'h0, P0_PRI});
    @(negedge clk);
    reset = 1'b0;
    step(2'b11, 2'b00, 2'b10, 32'h48, 32'h44, 32'h0, 32'h0, 2'b01, "t5.after");

    // 6: idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      step(2'b00, 2'b00, 2'b00, 32'h0, 32'h0, 32'h0, 32'h0, 2'b00, $sformatf("t6[%0d]", i));
      chk($sformatf("t6[%0d].wait_cnt", i), 32'(dut.wait_cnt), 32'h0);
    end

    // 7: starvation limit reached while port 1 asks for a lock -> full 4-beat burst
    for (int i = 0; i < 13; i++)
      step(2'b11, 2'b00, 2'b10, 32'h700 + 32'(i * 4), 32'h800 + 32'(i * 4), 32'h0, 32'h0,
           (i >= 8 && i <= 11) ? 2'b10 : 2'b01, $sformatf("t7[%0d]", i));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
